// File: rtl/frame_buf_arb_if.sv
// Bus bundle between the frame-buffer arbiter, its writer/reader clients and the memory.
// slave = arbiter side, master = clients + memory side.
interface frame_buf_arb_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 29
);
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ack;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  busy;
  logic                  mem_wr_en;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rd_data,
    output wr_ack, rd_data, rd_valid, busy,
           mem_wr_en, mem_rd_en, mem_wr_addr, mem_rd_addr, mem_wr_data
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rd_data,
    input  wr_ack, rd_data, rd_valid, busy,
           mem_wr_en, mem_rd_en, mem_wr_addr, mem_rd_addr, mem_wr_data
  );
endinterface

// File: rtl/frame_buf_arb.sv
// One-writer / one-reader arbiter for a slow multi-cycle frame-buffer memory.
// Define ARB_ROUND_ROBIN_EN for alternating grants; default build gives the writer fixed priority.
module frame_buf_arb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 29,
  parameter int unsigned ACC_CYCLES = 3
) (
  input  logic            i_clk,
  input  logic            i_reset,
  frame_buf_arb_if.slave  io_bus
);

  localparam int unsigned CNT_W = 4;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WR     = 2'd1;
  localparam logic [1:0] S_RD     = 2'd2;
  localparam logic [1:0] S_RD_CAP = 2'd3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  logic [1:0]            r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wr_data, w_wr_data_nxt;
  logic [DATA_WIDTH-1:0] r_rd_data, w_rd_data_nxt;
  logic                  r_wr_ack, w_wr_ack_nxt;
  logic                  r_rd_valid, w_rd_valid_nxt;
  logic                  r_busy, r_mem_wr_en, r_mem_rd_en;
  logic                  w_rd_elig, w_grant_wr, w_grant_rd;

  // A reader still holding rd_req during its own rd_valid cycle is not re-granted
  assign w_rd_elig = io_bus.rd_req & ~r_rd_valid;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_rd, w_last_rd_nxt;
  assign w_grant_wr = io_bus.wr_req & (~w_rd_elig | r_last_rd);
  assign w_grant_rd = w_rd_elig & (~io_bus.wr_req | ~r_last_rd);
`else
  assign w_grant_wr = io_bus.wr_req;
  assign w_grant_rd = w_rd_elig & ~io_bus.wr_req;
`endif

  // Next-state, counter and latched-request logic
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_data_nxt  = r_wr_data;
    w_rd_addr_nxt  = r_rd_addr;
    w_rd_data_nxt  = r_rd_data;
    w_wr_ack_nxt   = 1'b0;
    w_rd_valid_nxt = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    w_last_rd_nxt  = r_last_rd;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_grant_wr) begin
          w_state_nxt   = S_WR;
          w_cnt_nxt     = CNT_LOAD;
          w_wr_addr_nxt = io_bus.wr_addr;
          w_wr_data_nxt = io_bus.wr_data;
`ifdef ARB_ROUND_ROBIN_EN
          w_last_rd_nxt = 1'b0;
`endif
        end else if (w_grant_rd) begin
          w_state_nxt   = S_RD;
          w_cnt_nxt     = CNT_LOAD;
          w_rd_addr_nxt = io_bus.rd_addr;
`ifdef ARB_ROUND_ROBIN_EN
          w_last_rd_nxt = 1'b1;
`endif
        end
      end
      S_WR: begin
        if (r_cnt == CNT_ONE) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt    = r_cnt - CNT_ONE;
          w_wr_ack_nxt = (r_cnt == CNT_TWO);
        end
      end
      S_RD: begin
        if (r_cnt == CNT_ONE) begin
          w_state_nxt = S_RD_CAP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      S_RD_CAP: begin
        w_rd_data_nxt  = io_bus.mem_rd_data;
        w_rd_valid_nxt = 1'b1;
        w_state_nxt    = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; memory enables and busy are decoded from the next state
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_rd_addr   <= '0;
      r_rd_data   <= '0;
      r_wr_ack    <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_wr_en <= 1'b1;
      r_mem_rd_en <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_rd   <= 1'b1;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_rd_data   <= w_rd_data_nxt;
      r_wr_ack    <= w_wr_ack_nxt;
      r_rd_valid  <= w_rd_valid_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_mem_wr_en <= (w_state_nxt != S_WR);
      r_mem_rd_en <= (w_state_nxt != S_RD);
`ifdef ARB_ROUND_ROBIN_EN
      r_last_rd   <= w_last_rd_nxt;
`endif
    end
  end

  assign io_bus.wr_ack      = r_wr_ack;
  assign io_bus.rd_valid    = r_rd_valid;
  assign io_bus.rd_data     = r_rd_data;
  assign io_bus.busy        = r_busy;
  assign io_bus.mem_wr_en   = r_mem_wr_en;
  assign io_bus.mem_rd_en   = r_mem_rd_en;
  assign io_bus.mem_wr_addr = r_wr_addr;
  assign io_bus.mem_wr_data = r_wr_data;
  assign io_bus.mem_rd_addr = r_rd_addr;

endmodule

// File: tb/tb_frame_buf_arb.sv
// Bench for frame_buf_arb: vector table, corner-case sequences, then random traffic
// checked against a transaction-level model with a 64-word aliased memory.
`timescale 1ns/1ps
module tb_frame_buf_arb;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 29;
  localparam int unsigned ACC = 3;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic mem_init;
  logic mon_on;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  frame_buf_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  frame_buf_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_CYCLES(ACC)) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .io_bus (bus)
  );

  typedef struct {
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp_rd;
    int            exp_lat;
  } vec_t;

  logic [DW-1:0] emu_mem [64];
  logic [DW-1:0] ref_mem [64];

  function automatic logic [DW-1:0] pattern(input int i);
    return 32'h5A00_0000 | DW'(i);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory with registered read data, addressed by the low 6 bits
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) emu_mem[i] <= pattern(i);
      bus.mem_rd_data <= '0;
    end else begin
      if (!bus.mem_wr_en) emu_mem[bus.mem_wr_addr[5:0]] <= bus.mem_wr_data;
      if (!bus.mem_rd_en) bus.mem_rd_data <= emu_mem[bus.mem_rd_addr[5:0]];
    end
  end

  // Every cycle: enables exclusive, and an access never starts right after a busy cycle
  logic p_wr_en = 1'b1, p_rd_en = 1'b1, p_busy = 1'b0;
  always @(negedge clk) begin
    if (mon_on) begin
      check("en_excl", 64'(!bus.mem_wr_en && !bus.mem_rd_en), 64'd0);
      if ((!bus.mem_wr_en || !bus.mem_rd_en) && p_wr_en && p_rd_en)
        check("idle_gap", 64'(p_busy), 64'd0);
    end
    p_wr_en <= bus.mem_wr_en;
    p_rd_en <= bus.mem_rd_en;
    p_busy  <= bus.busy;
  end

  task automatic do_txn(input vec_t v, input int idx);
    int cyc, en_low;
    bit done, addr_ok;
    logic [DW-1:0] got;
    @(posedge clk); #1;
    if (v.is_wr) begin bus.wr_req = 1'b1; bus.wr_addr = v.addr; bus.wr_data = v.data; end
    else         begin bus.rd_req = 1'b1; bus.rd_addr = v.addr; end
    cyc = 0; en_low = 0; done = 1'b0; addr_ok = 1'b1; got = '0;
    while (!done && cyc < 40) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (v.is_wr && !bus.mem_wr_en) begin
        en_low++;
        if (bus.mem_wr_addr !== v.addr || bus.mem_wr_data !== v.data || bus.mem_rd_en !== 1'b1) addr_ok = 1'b0;
      end
      if (!v.is_wr && !bus.mem_rd_en) begin
        en_low++;
        if (bus.mem_rd_addr !== v.addr || bus.mem_wr_en !== 1'b1) addr_ok = 1'b0;
      end
      done = v.is_wr ? bus.wr_ack : bus.rd_valid;
      got  = bus.rd_data;
    end
    @(posedge clk); #1;
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    if (v.is_wr) ref_mem[v.addr[5:0]] = v.data;
    check($sformatf("v%0d_latency", idx), 64'(cyc), 64'(v.exp_lat));
    check($sformatf("v%0d_en_cycles", idx), 64'(en_low), 64'(ACC));
    check($sformatf("v%0d_mem_bus", idx), 64'(addr_ok), 64'd1);
    if (!v.is_wr) begin
      check($sformatf("v%0d_rd_data", idx), 64'(got), 64'(v.exp_rd));
      @(negedge clk);
      check($sformatf("v%0d_rd_hold", idx), 64'(bus.rd_data), 64'(v.exp_rd));
    end
  endtask

  vec_t vecs[8];
  vec_t v;
  int   cyc, found;
  bit   done, saw_valid;
  logic kinds[$];
  logic exp_kinds[4];
  logic pw, pr;

  // Random-phase model state
  int   m_kind, m_g, m_free, m_mask, k;
  bit   m_last_rd, wr_el, rd_el, gw, gr, wack_seen, rval_seen;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_exp_rd;
  logic e_wr_en, e_rd_en, e_ack, e_val, e_busy;

  initial begin
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    mon_on = 1'b0; mem_init = 1'b1; reset = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = pattern(i);

    vecs[0] = '{1'b1, 29'h10,       32'hDEAD_BEEF, 32'h0,          ACC};
    vecs[1] = '{1'b0, 29'h10,       32'h0,         32'hDEAD_BEEF,  ACC + 2};
    vecs[2] = '{1'b1, 29'h1FFF_FFFF, 32'hFFFF_FFFF, 32'h0,          ACC};
    vecs[3] = '{1'b0, 29'h1FFF_FFFF, 32'h0,         32'hFFFF_FFFF,  ACC + 2};
    vecs[4] = '{1'b1, 29'h0,        32'h0,         32'h0,          ACC};
    vecs[5] = '{1'b0, 29'h0,        32'h0,         32'h0,          ACC + 2};
    vecs[6] = '{1'b0, 29'h10,       32'h0,         32'hDEAD_BEEF,  ACC + 2};
    vecs[7] = '{1'b0, 29'h5,        32'h0,         32'h5A00_0005,  ACC + 2};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_enables", 64'({bus.mem_wr_en, bus.mem_rd_en}), 64'h3);
    check("rst_ack_valid_busy", 64'({bus.wr_ack, bus.rd_valid, bus.busy}), 64'h0);
    check("rst_rd_data", 64'(bus.rd_data), 64'h0);
    check("rst_mem_wr_addr", 64'(bus.mem_wr_addr), 64'h0);
    check("rst_mem_wr_data", 64'(bus.mem_wr_data), 64'h0);
    check("rst_mem_rd_addr", 64'(bus.mem_rd_addr), 64'h0);
    @(posedge clk); #1;
    reset = 1'b0; mem_init = 1'b0; mon_on = 1'b1;

    for (int i = 0; i < 8; i++) do_txn(vecs[i], i);

    // Writer drops its request one cycle after the grant
    @(posedge clk); #1;
    bus.wr_req = 1'b1; bus.wr_addr = 29'h22; bus.wr_data = 32'h1234_5678;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      @(posedge clk); cyc++;
      if (cyc == 2) begin #1; bus.wr_req = 1'b0; end
      @(negedge clk);
      done = bus.wr_ack;
    end
    check("drop_wr_latency", 64'(cyc), 64'(ACC));
    @(negedge clk);
    check("drop_wr_idle", 64'(bus.busy), 64'd0);
    ref_mem[6'h22] = 32'h1234_5678;
    v = '{1'b0, 29'h22, 32'h0, 32'h1234_5678, ACC + 2};
    do_txn(v, 100);

    // Reset pulsed during the second RD cycle
    @(posedge clk); #1;
    bus.rd_req = 1'b1; bus.rd_addr = 29'h10;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("rstmid_in_read", 64'(bus.mem_rd_en), 64'd0);
    reset = 1'b1; bus.rd_req = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rstmid_enables", 64'({bus.mem_wr_en, bus.mem_rd_en}), 64'h3);
    check("rstmid_flags", 64'({bus.rd_valid, bus.busy}), 64'h0);
    check("rstmid_rd_data", 64'(bus.rd_data), 64'h0);
    reset = 1'b0;
    saw_valid = 1'b0;
    repeat (8) begin @(negedge clk); if (bus.rd_valid) saw_valid = 1'b1; end
    check("rstmid_no_valid", 64'(saw_valid), 64'd0);

    // Both requests held high: grant order
    exp_kinds = RR ? '{1'b1, 1'b0, 1'b1, 1'b0} : '{1'b1, 1'b1, 1'b1, 1'b1};
    @(posedge clk); #1;
    bus.wr_req = 1'b1; bus.wr_addr = 29'h30; bus.wr_data = 32'hCAFE_0001;
    bus.rd_req = 1'b1; bus.rd_addr = 29'h31;
    ref_mem[6'h30] = 32'hCAFE_0001;
    kinds.delete(); pw = 1'b1; pr = 1'b1; cyc = 0;
    while (kinds.size() < 4 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (pw && pr && !bus.mem_wr_en) kinds.push_back(1'b1);
      else if (pw && pr && !bus.mem_rd_en) kinds.push_back(1'b0);
      pw = bus.mem_wr_en; pr = bus.mem_rd_en;
    end
    @(posedge clk); #1;
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    found = kinds.size();
    check("both_grant_count", 64'(found), 64'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("both_grant%0d_is_wr", i), 64'(i < found ? kinds[i] : 1'bx), 64'(exp_kinds[i]));
    repeat (10) @(posedge clk);

    // Random traffic against the transaction-level model
    #1; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    m_kind = 0; m_g = 0; m_free = 0; m_mask = -1; m_last_rd = 1'b1;
    m_addr = '0; m_data = '0; m_exp_rd = '0; wack_seen = 1'b0; rval_seen = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk);
      if (n >= m_free) begin
        wr_el = bus.wr_req;
        rd_el = bus.rd_req && (n != m_mask);
        gw = RR ? (wr_el && (!rd_el || m_last_rd)) : wr_el;
        gr = RR ? (rd_el && (!wr_el || !m_last_rd)) : (rd_el && !wr_el);
        if (gw) begin
          m_kind = 1; m_g = n; m_addr = bus.wr_addr; m_data = bus.wr_data;
          ref_mem[m_addr[5:0]] = m_data; m_free = n + ACC + 1; m_last_rd = 1'b0;
        end else if (gr) begin
          m_kind = 2; m_g = n; m_addr = bus.rd_addr; m_data = ref_mem[m_addr[5:0]];
          m_free = n + ACC + 2; m_mask = n + ACC + 2; m_last_rd = 1'b1;
        end
      end
      #1;
      if (!bus.wr_req) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.wr_req = 1'b1; bus.wr_addr = AW'($urandom); bus.wr_data = $urandom;
        end
      end else if (wack_seen) begin
        if ($urandom_range(0, 1) == 0) bus.wr_req = 1'b0;
        else begin bus.wr_addr = AW'($urandom); bus.wr_data = $urandom; end
      end
      if (!bus.rd_req) begin
        if ($urandom_range(0, 2) == 0) begin bus.rd_req = 1'b1; bus.rd_addr = AW'($urandom); end
      end else if (rval_seen) begin
        if ($urandom_range(0, 1) == 0) bus.rd_req = 1'b0;
        else bus.rd_addr = AW'($urandom);
      end
      @(negedge clk);
      k = n - m_g;
      e_wr_en = 1'b1; e_rd_en = 1'b1; e_ack = 1'b0; e_val = 1'b0; e_busy = 1'b0;
      if (m_kind == 1 && k < ACC) begin
        e_wr_en = 1'b0; e_busy = 1'b1; e_ack = (k == ACC - 1);
      end
      if (m_kind == 2) begin
        if (k < ACC) e_rd_en = 1'b0;
        if (k <= ACC) e_busy = 1'b1;
        if (k == ACC + 1) begin e_val = 1'b1; m_exp_rd = m_data; end
      end
      check($sformatf("rnd%0d_enables", n), 64'({bus.mem_wr_en, bus.mem_rd_en}), 64'({e_wr_en, e_rd_en}));
      check($sformatf("rnd%0d_ack_valid_busy", n), 64'({bus.wr_ack, bus.rd_valid, bus.busy}),
            64'({e_ack, e_val, e_busy}));
      check($sformatf("rnd%0d_rd_data", n), 64'(bus.rd_data), 64'(m_exp_rd));
      if (!e_wr_en)
        check($sformatf("rnd%0d_wr_bus", n), 64'({bus.mem_wr_addr, bus.mem_wr_data}), 64'({m_addr, m_data}));
      if (!e_rd_en)
        check($sformatf("rnd%0d_rd_addr", n), 64'(bus.mem_rd_addr), 64'(m_addr));
      wack_seen = bus.wr_ack;
      rval_seen = bus.rd_valid;
    end

    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
